// File: rtl/pacman_pkg.sv
// Shared maze geometry, direction codes and scheduler state encoding for the Pac-Man movement blocks.
package pacman_pkg;

  localparam logic [2:0] DIR_RIGHT = 3'd0;
  localparam logic [2:0] DIR_UP    = 3'd1;
  localparam logic [2:0] DIR_LEFT  = 3'd2;
  localparam logic [2:0] DIR_DOWN  = 3'd3;
  localparam logic [2:0] DIR_WAIT  = 3'd4;

  localparam int unsigned MAZE_W  = 27;
  localparam int unsigned MAZE_H  = 24;
  localparam int unsigned X_MAX   = MAZE_W - 1;
  localparam int unsigned Y_MAX   = MAZE_H - 1;
  localparam int unsigned MAZE_AW = 10;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitRd,
    StCheck
  } sched_state_e;

  // Linear wall-memory index of tile (x, y), row-major.
  function automatic logic [MAZE_AW-1:0] tile_addr(input logic [7:0] x, input logic [6:0] y);
    return MAZE_AW'(y) * MAZE_AW'(MAZE_W) + MAZE_AW'(x);
  endfunction

endpackage

// File: rtl/tile_step.sv
// Combinational one-tile step with toroidal wrap at the maze edges; codes above DOWN mean stay put.
module tile_step
  import pacman_pkg::*;
(
  input  logic [7:0] i_x,
  input  logic [6:0] i_y,
  input  logic [2:0] i_dir,
  output logic [7:0] o_cand_x,
  output logic [6:0] o_cand_y,
  output logic       o_is_wait
);

  always_comb begin
    o_cand_x  = i_x;
    o_cand_y  = i_y;
    o_is_wait = 1'b0;
    case (i_dir)
      DIR_RIGHT: o_cand_x = (i_x == 8'(X_MAX)) ? 8'd0 : i_x + 8'd1;
      DIR_UP:    o_cand_y = (i_y == 7'd0) ? 7'(Y_MAX) : i_y - 7'd1;
      DIR_LEFT:  o_cand_x = (i_x == 8'd0) ? 8'(X_MAX) : i_x - 8'd1;
      DIR_DOWN:  o_cand_y = (i_y == 7'(Y_MAX)) ? 7'd0 : i_y + 7'd1;
      default:   o_is_wait = 1'b1;
    endcase
  end

endmodule

// File: rtl/actor_move_scheduler.sv
// Steps every actor once per tick through a shared single-port wall memory, in actor order,
// and reports a Pac-Man/ghost tile overlap when the step completes.
module actor_move_scheduler
  import pacman_pkg::*;
#(
  parameter int unsigned NUM_ACTORS = 5,
  parameter int unsigned PAC_X      = 13,
  parameter int unsigned PAC_Y      = 17,
  parameter int unsigned GHOST_X    = 13,
  parameter int unsigned GHOST_Y    = 11
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_tick,
  input  logic [3*NUM_ACTORS-1:0]   i_dir_in,
  output logic                      o_maze_rd,
  output logic [MAZE_AW-1:0]        o_maze_addr,
  input  logic                      i_maze_wall,
  output logic [8*NUM_ACTORS-1:0]   o_x_out,
  output logic [7*NUM_ACTORS-1:0]   o_y_out,
  output logic [3*NUM_ACTORS-1:0]   o_dir_out,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_collision
);

  localparam int unsigned IdxW = (NUM_ACTORS > 1) ? $clog2(NUM_ACTORS) : 1;

  sched_state_e    r_state, w_state_d;
  logic [IdxW-1:0] r_idx;
  logic [2:0]      r_dir_q [NUM_ACTORS];
  logic [7:0]      r_x     [NUM_ACTORS];
  logic [6:0]      r_y     [NUM_ACTORS];
  logic [2:0]      r_dir   [NUM_ACTORS];
  logic [7:0]      r_cand_x;
  logic [6:0]      r_cand_y;

  logic [7:0] w_cur_x, w_cand_x;
  logic [6:0] w_cur_y, w_cand_y;
  logic [2:0] w_cur_dir;
  logic       w_is_wait;
  logic       w_last;
  logic       w_overlap;

  always_comb begin
    w_cur_x   = '0;
    w_cur_y   = '0;
    w_cur_dir = DIR_WAIT;
    for (int i = 0; i < NUM_ACTORS; i++) begin
      if (r_idx == IdxW'(i)) begin
        w_cur_x   = r_x[i];
        w_cur_y   = r_y[i];
        w_cur_dir = r_dir_q[i];
      end
    end
  end

  assign w_last = (r_idx == IdxW'(NUM_ACTORS - 1));

  tile_step u_tile_step (
    .i_x       (w_cur_x),
    .i_y       (w_cur_y),
    .i_dir     (w_cur_dir),
    .o_cand_x  (w_cand_x),
    .o_cand_y  (w_cand_y),
    .o_is_wait (w_is_wait)
  );

  // Ghosts sharing a tile with each other are deliberately not reported.
  always_comb begin
    w_overlap = 1'b0;
    for (int i = 1; i < NUM_ACTORS; i++) begin
      if ((r_x[i] == r_x[0]) && (r_y[i] == r_y[0])) begin
        w_overlap = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    o_maze_rd   = 1'b0;
    o_maze_addr = '0;
    o_done      = 1'b0;
    o_collision = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_tick) begin
          w_state_d = StIssue;
        end
      end
      StIssue: begin
        if (w_is_wait) begin
          w_state_d = w_last ? StCheck : StIssue;
        end else begin
          o_maze_rd   = 1'b1;
          o_maze_addr = tile_addr(w_cand_x, w_cand_y);
          w_state_d   = StWaitRd;
        end
      end
      StWaitRd: begin
        w_state_d = w_last ? StCheck : StIssue;
      end
      StCheck: begin
        o_done      = 1'b1;
        o_collision = w_overlap;
        w_state_d   = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign o_busy = (r_state != StIdle);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_idx    <= '0;
      r_cand_x <= '0;
      r_cand_y <= '0;
      for (int i = 0; i < NUM_ACTORS; i++) begin
        r_dir_q[i] <= DIR_WAIT;
        r_x[i]     <= (i == 0) ? 8'(PAC_X) : 8'(GHOST_X);
        r_y[i]     <= (i == 0) ? 7'(PAC_Y) : 7'(GHOST_Y);
        r_dir[i]   <= DIR_WAIT;
      end
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_tick) begin
            r_idx <= '0;
            for (int i = 0; i < NUM_ACTORS; i++) begin
              r_dir_q[i] <= i_dir_in[3*i +: 3];
            end
          end
        end
        StIssue: begin
          if (w_is_wait) begin
            for (int i = 0; i < NUM_ACTORS; i++) begin
              if (r_idx == IdxW'(i)) begin
                r_dir[i] <= DIR_WAIT;
              end
            end
            if (!w_last) begin
              r_idx <= r_idx + 1'b1;
            end
          end else begin
            r_cand_x <= w_cand_x;
            r_cand_y <= w_cand_y;
          end
        end
        StWaitRd: begin
          // Commit now so later actors see this actor's new tile.
          for (int i = 0; i < NUM_ACTORS; i++) begin
            if (r_idx == IdxW'(i)) begin
              if (!i_maze_wall) begin
                r_x[i]   <= r_cand_x;
                r_y[i]   <= r_cand_y;
                r_dir[i] <= w_cur_dir;
              end else begin
                r_dir[i] <= DIR_WAIT;
              end
            end
          end
          if (!w_last) begin
            r_idx <= r_idx + 1'b1;
          end
        end
        StCheck: begin
          r_idx <= '0;
        end
        default: r_idx <= '0;
      endcase
    end
  end

  always_comb begin
    o_x_out   = '0;
    o_y_out   = '0;
    o_dir_out = '0;
    for (int i = 0; i < NUM_ACTORS; i++) begin
      o_x_out[8*i +: 8]   = r_x[i];
      o_y_out[7*i +: 7]   = r_y[i];
      o_dir_out[3*i +: 3] = r_dir[i];
    end
  end

endmodule

// File: tb/tb_actor_move_scheduler.sv
// Randomized and directed bench for actor_move_scheduler against a modular-arithmetic move model.
module tb_actor_move_scheduler;

  localparam int N = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic [14:0] dir_in;
  logic        maze_rd;
  logic [9:0]  maze_addr;
  logic        maze_wall = 1'b0;
  logic [39:0] x_out;
  logic [34:0] y_out;
  logic [14:0] dir_out;
  logic        busy;
  logic        done;
  logic        collision;

  always #5 clk = ~clk;

  actor_move_scheduler dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_tick      (tick),
    .i_dir_in    (dir_in),
    .o_maze_rd   (maze_rd),
    .o_maze_addr (maze_addr),
    .i_maze_wall (maze_wall),
    .o_x_out     (x_out),
    .o_y_out     (y_out),
    .o_dir_out   (dir_out),
    .o_busy      (busy),
    .o_done      (done),
    .o_collision (collision)
  );

  bit          mem [648];
  int          mx [N];
  int          my [N];
  int          mdir [N];
  int unsigned rd_q [$];
  int unsigned exp_q [$];
  int          done_cnt = 0;
  int          n_checks = 0;
  int          n_fails  = 0;

  // Wall memory with one cycle of read latency; garbage when not read.
  always @(posedge clk) begin
    if (maze_rd) maze_wall <= (maze_addr < 10'd648) ? mem[maze_addr] : 1'b1;
    else         maze_wall <= 1'($urandom);
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (maze_rd) rd_q.push_back(int'(maze_addr));
      if (done) done_cnt++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] mk(input int d0, input int d1, input int d2, input int d3,
                                     input int d4);
    return {3'(d4), 3'(d3), 3'(d2), 3'(d1), 3'(d0)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mx[i]   = (i == 0) ? 13 : 13;
      my[i]   = (i == 0) ? 17 : 11;
      mdir[i] = 4;
    end
  endtask

  task automatic check_outputs(input string tag);
    for (int i = 0; i < N; i++) begin
      check_eq($sformatf("%s_x%0d", tag, i), 32'(x_out[8*i +: 8]), 32'(mx[i]));
      check_eq($sformatf("%s_y%0d", tag, i), 32'(y_out[7*i +: 7]), 32'(my[i]));
      check_eq($sformatf("%s_dir%0d", tag, i), 32'(dir_out[3*i +: 3]), 32'(mdir[i]));
    end
  endtask

  task automatic run_step(input logic [14:0] dirs, input bit spam, output logic coll_obs);
    int   m;
    int   s;
    int   k;
    int   d;
    int   cx;
    int   cy;
    int   a;
    int   dn0;
    logic exp_coll;
    m = 0;
    s = 0;
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      d = int'(dirs[3*i +: 3]);
      if (d >= 4) begin
        mdir[i] = 4;
        s++;
      end else begin
        cx = mx[i];
        cy = my[i];
        case (d)
          0: cx = (cx + 1) % 27;
          1: cy = (cy + 23) % 24;
          2: cx = (cx + 26) % 27;
          default: cy = (cy + 1) % 24;
        endcase
        a = cy * 27 + cx;
        exp_q.push_back(a);
        m++;
        if (!mem[a]) begin
          mx[i] = cx;
          my[i] = cy;
          mdir[i] = d;
        end else begin
          mdir[i] = 4;
        end
      end
    end
    exp_coll = 1'b0;
    for (int i = 1; i < N; i++) begin
      if (mx[i] == mx[0] && my[i] == my[0]) exp_coll = 1'b1;
    end

    @(negedge clk);
    rd_q.delete();
    dn0    = done_cnt;
    dir_in = dirs;
    tick   = 1'b1;
    @(posedge clk);
    k = 0;
    while (k < 40) begin
      k++;
      @(negedge clk);
      tick   = spam;
      dir_in = 15'($urandom);
      if (done) break;
    end
    check_eq("done_cycle", 32'(k), 32'(2 * m + s + 1));
    coll_obs = collision;
    check_eq("collision", 32'(collision), 32'(exp_coll));
    @(negedge clk);
    tick = 1'b0;
    check_eq("busy_after", 32'(busy), 32'd0);
    check_eq("done_after", 32'(done), 32'd0);
    check_outputs("step");
    if (spam) repeat (4) @(negedge clk);
    check_eq("done_count", 32'(done_cnt - dn0), 32'd1);
    check_eq("rd_count", 32'(rd_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rd_q.size(); i++) begin
      check_eq($sformatf("rd_addr%0d", i), 32'(rd_q[i]), 32'(exp_q[i]));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic c;
    int   dn0;
    rst    = 1'b1;
    tick   = 1'b0;
    dir_in = '0;
    foreach (mem[i]) mem[i] = 1'b0;
    model_reset();

    repeat (3) @(negedge clk);
    check_outputs("reset");
    check_eq("reset_busy", 32'(busy), 32'd0);
    check_eq("reset_done", 32'(done), 32'd0);
    check_eq("reset_coll", 32'(collision), 32'd0);
    check_eq("reset_rd", 32'(maze_rd), 32'd0);
    check_eq("reset_addr", 32'(maze_addr), 32'd0);
    rst = 1'b0;
    rd_q.delete();
    repeat (20) @(negedge clk);
    check_eq("idle_rd_count", 32'(rd_q.size()), 32'd0);
    check_eq("idle_done_count", 32'(done_cnt), 32'd0);
    check_eq("idle_busy", 32'(busy), 32'd0);

    // Pac-Man one step right in an open maze.
    run_step(mk(0, 4, 4, 4, 4), 1'b0, c);
    check_eq("first_addr", (rd_q.size() > 0) ? 32'(rd_q[0]) : 32'd0, 32'd473);
    check_eq("pac_x_14", 32'(x_out[7:0]), 32'd14);
    check_eq("pac_y_17", 32'(y_out[6:0]), 32'd17);

    // Drive Pac-Man across the right edge and ghost 1 across the top edge.
    for (int j = 0; j < 13; j++) run_step(mk(0, 1, 4, 4, 4), 1'b0, c);
    check_eq("pac_wrap_x", 32'(x_out[7:0]), 32'd0);
    check_eq("g1_wrap_y", 32'(y_out[13:7]), 32'd22);

    // Wall ahead of Pac-Man; ghost 2 moves freely in the same step.
    mem[460] = 1'b1;
    run_step(mk(0, 4, 0, 4, 4), 1'b0, c);
    check_eq("pac_blocked_x", 32'(x_out[7:0]), 32'd0);
    check_eq("pac_blocked_dir", 32'(dir_out[2:0]), 32'd4);
    check_eq("g2_moved_x", 32'(x_out[23:16]), 32'd14);
    check_eq("g2_moved_dir", 32'(dir_out[8:6]), 32'd0);
    mem[460] = 1'b0;

    // Bring ghost 2 onto Pac-Man's tile in the final step.
    for (int j = 0; j < 12; j++) run_step(mk(2, 4, (j < 5) ? 3 : 4, 4, 4), 1'b0, c);
    check_eq("no_overlap", 32'(c), 32'd0);
    run_step(mk(2, 4, 3, 4, 4), 1'b0, c);
    check_eq("collision_hit", 32'(c), 32'd1);

    // Ticks held high throughout the step, including the done cycle.
    run_step(mk(1, 2, 3, 0, 1), 1'b1, c);

    // Random walls and directions, including the 5..7 wait aliases.
    foreach (mem[i]) mem[i] = ($urandom_range(0, 3) == 0);
    for (int j = 0; j < 30; j++) begin
      run_step(mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 7)), 1'($urandom_range(0, 1)), c);
    end
    foreach (mem[i]) mem[i] = 1'b0;

    // Reset while actor 1 waits on its wall read.
    @(negedge clk);
    dir_in = mk(0, 0, 0, 0, 0);
    tick   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tick = 1'b0;
    repeat (3) @(negedge clk);
    dn0 = done_cnt;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("midrst");
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    check_eq("midrst_no_done", 32'(done_cnt - dn0), 32'd0);
    check_eq("midrst_idle", 32'(busy), 32'd0);
    check_outputs("postrst");

    run_step(mk(0, 4, 4, 4, 4), 1'b0, c);
    check_eq("rerun_addr", (rd_q.size() > 0) ? 32'(rd_q[0]) : 32'd0, 32'd473);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
